// File: rtl/mp_pkg.sv
// Shared constants and FSM state type for the multi-precision row controller.
package mp_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned TOTAL_ADDR = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/MultiplyAdd.sv
// Word-level multiply-accumulate: {cout, s} = x * y + z + cin, exact in 2*Width bits.
module MultiplyAdd #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] x_i,
  input  logic [Width-1:0] y_i,
  input  logic [Width-1:0] z_i,
  input  logic [Width-1:0] cin_i,
  output logic [Width-1:0] s_o,
  output logic [Width-1:0] cout_o
);

  logic [2*Width-1:0] prod;
  logic [2*Width-1:0] sum;

  // (2^W-1)^2 + 2*(2^W-1) = 2^(2W)-1, so the sum never overflows 2*Width bits.
  assign prod = {{Width{1'b0}}, x_i} * {{Width{1'b0}}, y_i};
  assign sum  = prod + {{Width{1'b0}}, z_i} + {{Width{1'b0}}, cin_i};

  assign s_o    = sum[Width-1:0];
  assign cout_o = sum[2*Width-1:Width];

endmodule

// File: rtl/mul_add_row_ctrl.sv
// Row controller: streams R[i] = A[i]*b + C[i] + k_i through MultiplyAdd, one word per cycle,
// reading A and C from synchronous RAMs and writing R through a registered port.
module mul_add_row_ctrl #(
  parameter int unsigned DATA_WIDTH = mp_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = mp_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [DATA_WIDTH-1:0] b_word,
  input  logic [DATA_WIDTH-1:0] carry_in,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_wdata,
  output logic                  r_we,
  output logic [DATA_WIDTH-1:0] carry_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   MaxWords = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   WordOne  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  mp_pkg::state_e        state_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] carry_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic                  r_we_q;
  logic [DATA_WIDTH-1:0] carry_out_q;
  logic                  done_q;

  logic [ADDR_WIDTH:0]   n_sat;
  logic [ADDR_WIDTH:0]   last_word;
  logic                  last_idx;
  logic                  addr_at_end;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] mac_s;
  logic [DATA_WIDTH-1:0] mac_cout;

  MultiplyAdd #(
    .Width (DATA_WIDTH)
  ) u_mac (
    .x_i    (a_rdata),
    .y_i    (b_q),
    .z_i    (c_rdata),
    .cin_i  (carry_q),
    .s_o    (mac_s),
    .cout_o (mac_cout)
  );

  assign n_sat       = (num_words > MaxWords) ? MaxWords : num_words;
  assign last_word   = n_q - WordOne;
  assign last_idx    = ({1'b0, idx_q} == last_word);
  // Hold the read address on the last word so nothing beyond n-1 is fetched.
  assign addr_at_end = ({1'b0, addr_q} == last_word);
  assign addr_next   = addr_at_end ? addr_q : addr_q + AddrOne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= mp_pkg::StIdle;
      n_q         <= '0;
      b_q         <= '0;
      carry_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      r_addr_q    <= '0;
      r_wdata_q   <= '0;
      r_we_q      <= 1'b0;
      carry_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        mp_pkg::StIdle: begin
          done_q <= 1'b0;
          r_we_q <= 1'b0;
          if (start) begin
            n_q     <= n_sat;
            b_q     <= b_word;
            carry_q <= carry_in;
            idx_q   <= '0;
            addr_q  <= '0;
            if (n_sat == '0) begin
              // Empty row completes without leaving IDLE, so busy never rises.
              done_q      <= 1'b1;
              carry_out_q <= carry_in;
            end else begin
              state_q <= mp_pkg::StFill;
            end
          end
        end
        mp_pkg::StFill: begin
          addr_q  <= addr_next;
          idx_q   <= '0;
          state_q <= mp_pkg::StRun;
        end
        mp_pkg::StRun: begin
          r_wdata_q <= mac_s;
          r_addr_q  <= idx_q;
          r_we_q    <= 1'b1;
          carry_q   <= mac_cout;
          if (last_idx) begin
            state_q     <= mp_pkg::StDone;
            done_q      <= 1'b1;
            carry_out_q <= mac_cout;
          end else begin
            idx_q  <= idx_q + AddrOne;
            addr_q <= addr_next;
          end
        end
        mp_pkg::StDone: begin
          done_q  <= 1'b0;
          r_we_q  <= 1'b0;
          state_q <= mp_pkg::StIdle;
        end
        default: begin
          state_q <= mp_pkg::StIdle;
        end
      endcase
    end
  end

  assign a_addr    = addr_q;
  assign c_addr    = addr_q;
  assign r_addr    = r_addr_q;
  assign r_wdata   = r_wdata_q;
  assign r_we      = r_we_q;
  assign carry_out = carry_out_q;
  assign done      = done_q;
  assign busy      = (state_q != mp_pkg::StIdle);

endmodule
